// File: rtl/system_onchip_burst_bridge.sv
// Burst-to-single-beat bridge between a bursting slave port and a simple
// synchronous on-chip RAM. Write beats are registered and forwarded one per
// accepted beat; read bursts are unrolled into back-to-back RAM reads and the
// RAM output is returned one cycle after each read issue.
module system_onchip_burst_bridge #(
   parameter int ADDR_W    = 13,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] s_address,
   input  logic [4:0]        s_burstcount,
   input  logic              s_read,
   input  logic              s_write,
   input  logic [31:0]       s_writedata,
   input  logic [3:0]        s_byteenable,
   output logic              s_waitrequest,
   output logic [31:0]       s_readdata,
   output logic              s_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [31:0]       ram_writedata,
   input  logic [31:0]       ram_readdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   localparam logic [4:0] MAX_CNT = 5'(MAX_BURST);

   logic [1:0]        state_q, state_d;
   logic [4:0]        remain_q, remain_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic              rdv_q, rdv_d;
   logic [4:0]        count_eff;

   // Normalise the requested burst length: 0 means 1, oversize is clamped
   always_comb begin
      if (s_burstcount == 5'd0) begin
         count_eff = 5'd1;
      end else if (s_burstcount > MAX_CNT) begin
         count_eff = MAX_CNT;
      end else begin
         count_eff = s_burstcount;
      end
   end

   // Next-state logic: command decode, beat counting and RAM strobe generation
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      // read data returns exactly one cycle after each read issue
      rdv_d    = cs_q & ~we_q;
      case (state_q)
         ST_IDLE: begin
            // a write wins when both commands are presented together
            if (s_write) begin
               addr_d   = s_address;
               wdata_d  = s_writedata;
               be_d     = s_byteenable;
               cs_d     = 1'b1;
               we_d     = 1'b1;
               remain_d = count_eff - 5'd1;
               state_d  = (count_eff == 5'd1) ? ST_IDLE : ST_WR;
            end else if (s_read) begin
               addr_d   = s_address;
               be_d     = 4'hF;
               cs_d     = 1'b1;
               remain_d = count_eff - 5'd1;
               state_d  = ST_RD;
            end
         end
         ST_RD: begin
            // cs_q is the read being issued now; queue the next one if any remain
            if (remain_q == 5'd0) begin
               state_d = ST_IDLE;
            end else begin
               addr_d   = addr_q + ADDR_W'(1);
               cs_d     = 1'b1;
               remain_d = remain_q - 5'd1;
            end
         end
         ST_WR: begin
            // addr_q still holds the previous beat's address, so a pause costs nothing
            if (s_write) begin
               addr_d   = addr_q + ADDR_W'(1);
               wdata_d  = s_writedata;
               be_d     = s_byteenable;
               cs_d     = 1'b1;
               we_d     = 1'b1;
               remain_d = remain_q - 5'd1;
               if (remain_q == 5'd1) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any burst in flight
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         remain_q <= 5'd0;
         addr_q   <= '0;
         be_q     <= 4'h0;
         wdata_q  <= 32'h0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         rdv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         rdv_q    <= rdv_d;
      end
   end

   assign s_waitrequest   = (state_q == ST_RD);
   assign s_readdata      = ram_readdata;
   assign s_readdatavalid = rdv_q;
   assign ram_address     = addr_q;
   assign ram_byteenable  = be_q;
   assign ram_chipselect  = cs_q;
   assign ram_write       = we_q;
   assign ram_writedata   = wdata_q;

endmodule

// File: tb/tb_system_onchip_burst_bridge.sv
// Directed bench for the burst bridge: the stimulus pushes every expected RAM
// access and read return into scoreboard queues, a negedge monitor pops and
// compares them, and the stimulus also checks cycle-exact timing points.
module tb_system_onchip_burst_bridge;

   localparam int ADDR_W = 13;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic [3:0]        be;
   } acc_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [ADDR_W-1:0] s_address = '0;
   logic [4:0]        s_burstcount = 5'd0;
   logic              s_read = 1'b0;
   logic              s_write = 1'b0;
   logic [31:0]       s_writedata = 32'h0;
   logic [3:0]        s_byteenable = 4'h0;
   logic              s_waitrequest;
   logic [31:0]       s_readdata;
   logic              s_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect;
   logic              ram_write;
   logic [31:0]       ram_writedata;
   logic [31:0]       ram_readdata = 32'h0;

   int checks = 0;
   int failures = 0;
   int wr_seen = 0;
   int rd_seen = 0;
   int rdv_seen = 0;

   acc_t        exp_acc[$];
   logic [31:0] exp_rdv[$];

   system_onchip_burst_bridge #(.ADDR_W(ADDR_W), .MAX_BURST(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_address(s_address), .s_burstcount(s_burstcount),
      .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   // RAM model: q appears in the cycle after a read access
   always @(posedge clk) begin
      if (ram_chipselect && !ram_write) ram_readdata <= pat(ram_address);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      acc_t e;
      e.wr = 1'b1; e.addr = a; e.data = d; e.be = be;
      exp_acc.push_back(e);
   endtask

   task automatic push_rd(input logic [ADDR_W-1:0] a);
      acc_t e;
      e.wr = 1'b0; e.addr = a; e.data = 32'h0; e.be = 4'hF;
      exp_acc.push_back(e);
      exp_rdv.push_back(pat(a));
   endtask

   // Monitor: compare every RAM access and read return against the scoreboard
   always @(negedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) wr_seen++; else rd_seen++;
         if (exp_acc.size() == 0) begin
            check("unexpected_access", 64'(ram_address), 64'h1FFFF);
         end else begin
            acc_t e;
            e = exp_acc.pop_front();
            check("acc_kind", 64'(ram_write), 64'(e.wr));
            check("acc_addr", 64'(ram_address), 64'(e.addr));
            check("acc_be", 64'(ram_byteenable), 64'(e.be));
            if (e.wr) check("acc_wdata", 64'(ram_writedata), 64'(e.data));
         end
      end
      if (s_readdatavalid) begin
         rdv_seen++;
         if (exp_rdv.size() == 0) begin
            check("unexpected_rdv", 64'(s_readdata), 64'h1_0000_0000);
         end else begin
            logic [31:0] d;
            d = exp_rdv.pop_front();
            check("rdv_data", 64'(s_readdata), 64'(d));
         end
      end
   end

   initial begin
      int w0, r0, v0;

      // reset state
      tick(); tick(); tick();
      check("rst_wait", 64'(s_waitrequest), 64'h0);
      check("rst_cs", 64'(ram_chipselect), 64'h0);
      check("rst_we", 64'(ram_write), 64'h0);
      check("rst_rdv", 64'(s_readdatavalid), 64'h0);
      check("rst_addr", 64'(ram_address), 64'h0);
      check("rst_be", 64'(ram_byteenable), 64'h0);
      check("rst_wdata", 64'(ram_writedata), 64'h0);
      reset_n = 1'b1;
      tick();

      // single write
      s_write = 1'b1; s_address = 13'h010; s_burstcount = 5'd1;
      s_writedata = 32'hDEADBEEF; s_byteenable = 4'hF;
      push_wr(13'h010, 32'hDEADBEEF, 4'hF);
      check("sw_wait0", 64'(s_waitrequest), 64'h0);
      tick();
      s_write = 1'b0;
      check("sw_we", 64'(ram_write), 64'h1);
      check("sw_addr", 64'(ram_address), 64'h010);
      check("sw_wait1", 64'(s_waitrequest), 64'h0);
      tick();
      check("sw_idle_we", 64'(ram_write), 64'h0);
      check("sw_hold_addr", 64'(ram_address), 64'h010);

      // read burst across the address wrap
      s_read = 1'b1; s_address = 13'h1FFE; s_burstcount = 5'd4;
      push_rd(13'h1FFE); push_rd(13'h1FFF); push_rd(13'h0000); push_rd(13'h0001);
      tick();
      s_read = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         check($sformatf("rb_wait_c%0d", i), 64'(s_waitrequest), 64'(i <= 4));
         check($sformatf("rb_cs_c%0d", i), 64'(ram_chipselect), 64'(i <= 4));
         check($sformatf("rb_rdv_c%0d", i), 64'(s_readdatavalid), 64'(i >= 2 && i <= 5));
         tick();
      end

      // paused write burst
      w0 = wr_seen;
      s_write = 1'b1; s_address = 13'h100; s_burstcount = 5'd3;
      s_writedata = 32'h1111_0000; s_byteenable = 4'h3;
      push_wr(13'h100, 32'h1111_0000, 4'h3);
      tick();
      s_writedata = 32'h2222_0001; s_byteenable = 4'hC; s_address = 13'h0;
      push_wr(13'h101, 32'h2222_0001, 4'hC);
      tick();
      s_write = 1'b0;
      tick();
      check("pw_pause1_we", 64'(ram_write), 64'h0);
      check("pw_pause_addr", 64'(ram_address), 64'h101);
      tick();
      check("pw_pause2_we", 64'(ram_write), 64'h0);
      s_write = 1'b1; s_writedata = 32'h3333_0002; s_byteenable = 4'hF;
      push_wr(13'h102, 32'h3333_0002, 4'hF);
      tick();
      s_write = 1'b0;
      check("pw_b3_we", 64'(ram_write), 64'h1);
      check("pw_b3_addr", 64'(ram_address), 64'h102);
      tick();
      check("pw_count", 64'(wr_seen - w0), 64'd3);

      // simultaneous read and write: write wins
      w0 = wr_seen; r0 = rd_seen; v0 = rdv_seen;
      s_read = 1'b1; s_write = 1'b1; s_address = 13'h200; s_burstcount = 5'd2;
      s_writedata = 32'hAAAA_5555; s_byteenable = 4'hF;
      push_wr(13'h200, 32'hAAAA_5555, 4'hF);
      tick();
      s_read = 1'b0; s_writedata = 32'h5555_AAAA;
      check("rw_wait", 64'(s_waitrequest), 64'h0);
      push_wr(13'h201, 32'h5555_AAAA, 4'hF);
      tick();
      s_write = 1'b0;
      tick(); tick();
      check("rw_writes", 64'(wr_seen - w0), 64'd2);
      check("rw_reads", 64'(rd_seen - r0), 64'd0);
      check("rw_rdv", 64'(rdv_seen - v0), 64'd0);

      // reset in the middle of a count-8 read burst
      s_read = 1'b1; s_address = 13'h040; s_burstcount = 5'd8;
      push_rd(13'h040);
      exp_acc.push_back('{wr: 1'b0, addr: 13'h041, data: 32'h0, be: 4'hF});
      tick();
      s_read = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      check("ra_wait", 64'(s_waitrequest), 64'h0);
      check("ra_cs", 64'(ram_chipselect), 64'h0);
      check("ra_rdv", 64'(s_readdatavalid), 64'h0);
      reset_n = 1'b1;
      tick();
      check("ra_rdv2", 64'(s_readdatavalid), 64'h0);
      check("ra_q_empty", 64'(exp_acc.size() + exp_rdv.size()), 64'd0);
      s_read = 1'b1; s_address = 13'h005; s_burstcount = 5'd1;
      push_rd(13'h005);
      tick();
      s_read = 1'b0;
      check("ra_rd_cs", 64'(ram_chipselect), 64'h1);
      check("ra_rd_addr", 64'(ram_address), 64'h005);
      check("ra_rd_rdv0", 64'(s_readdatavalid), 64'h0);
      tick();
      check("ra_rd_rdv1", 64'(s_readdatavalid), 64'h1);
      check("ra_rd_data", 64'(s_readdata), 64'(pat(13'h005)));
      tick();

      // back-to-back: write accepted while the last read beat returns
      s_read = 1'b1; s_address = 13'h300; s_burstcount = 5'd2;
      push_rd(13'h300); push_rd(13'h301);
      tick();
      s_read = 1'b0;
      tick();
      tick();
      check("bb_rdv", 64'(s_readdatavalid), 64'h1);
      check("bb_wait", 64'(s_waitrequest), 64'h0);
      s_write = 1'b1; s_address = 13'h400; s_burstcount = 5'd1;
      s_writedata = 32'h0BAD_F00D; s_byteenable = 4'h5;
      push_wr(13'h400, 32'h0BAD_F00D, 4'h5);
      tick();
      s_write = 1'b0;
      check("bb_we", 64'(ram_write), 64'h1);
      check("bb_addr", 64'(ram_address), 64'h400);
      tick();

      // burst count 0 behaves as 1: the next beat is a fresh command
      s_write = 1'b1; s_address = 13'h500; s_burstcount = 5'd0;
      s_writedata = 32'h0000_0500; s_byteenable = 4'hF;
      push_wr(13'h500, 32'h0000_0500, 4'hF);
      tick();
      s_address = 13'h600; s_burstcount = 5'd1; s_writedata = 32'h0000_0600;
      push_wr(13'h600, 32'h0000_0600, 4'hF);
      tick();
      s_write = 1'b0;
      check("c0_addr", 64'(ram_address), 64'h600);
      tick();

      // oversize burst count clamps to 16 beats
      r0 = rd_seen;
      s_read = 1'b1; s_address = 13'h700; s_burstcount = 5'd31;
      for (int i = 0; i < 16; i++) push_rd(13'h700 + 13'(i));
      tick();
      s_read = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("clamp_reads", 64'(rd_seen - r0), 64'd16);
      check("clamp_wait", 64'(s_waitrequest), 64'h0);
      check("end_q_empty", 64'(exp_acc.size() + exp_rdv.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
